baggage_drop_seq: RTL and testbench
===================================

Name: baggage_drop_seq

Overview:
Parametrised, clocked successor to the combinational baggage-drop path.
- Fuses NUM_SENSORS height readings into a mean height h.
- Computes fall time t = sqrt(h) in fixed point with iterative divide and square-root engines, then halves it to t_act.
- Compares t_act with t_lim and drives drop_activated plus a 4-digit seven-segment message.
- Uses a start/busy/done handshake. Sits between the sensor front-end and the drop actuator/display.

Parameters:
NUM_SENSORS, 4, number of height sensors (>=1).
SENSOR_W, 8, bits per sensor reading. Must be even.
FRAC_BITS, 8, fractional bits of t and t_act.
T_W, 16, width of t_lim and t_act. Elaboration error if T_W < SENSOR_W/2+FRAC_BITS.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request a computation; sampled only in IDLE
sensors  in  NUM_SENSORS*SENSOR_W  packed readings, sensor i at bits [i*SENSOR_W +: SENSOR_W]
t_lim  in  T_W  time limit, same fixed-point format as t_act
drop_en  in  1  drop enable
busy  out  1  high from the accept edge until the done edge
done  out  1  one-cycle pulse when results update
t_act  out  T_W  last computed t/2
drop_activated  out  1  last drop decision
seven_seg1..seven_seg4  out  7 each  message digits, seg1 leftmost, bit order gfedcba, active-high

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: state IDLE, busy=0, done=0, t_act=0, drop_activated=0, all seven_seg*=7'b0 (blank).
- Reset mid-operation: the computation is aborted immediately. No done pulse is produced.
- States: IDLE, DIV, SQRT, DECIDE.
- IDLE:
  - On an edge with start=1, capture sensors, t_lim and drop_en.
  - Register sum S = sum of the nonzero readings, and count C = number of nonzero readings.
  - S is SUM_W = SENSOR_W + clog2(NUM_SENSORS) bits wide (minimum 1 extra bit).
  - Set busy=1 and go to DIV.
- Start while busy: ignored. Inputs are not re-sampled.
- DIV: restoring divide h = floor(S/C), exactly SUM_W cycles.
  - If C=0, h=0. The full cycle count still runs, so latency is constant.
  - h is saturated to SENSOR_W bits (cannot overflow in practice).
- SQRT: digit-by-digit integer square root of R = h << (2*FRAC_BITS).
  - Runs exactly (SENSOR_W+2*FRAC_BITS)/2 cycles.
  - Result t = floor(sqrt(R)), a fixed-point value with FRAC_BITS fractional bits.
- DECIDE: one cycle, then return to IDLE. On the exit edge:
  - t_act <= zero-extend(t >> 1), i.e. floor.
  - drop_activated <= drop_en && (t_act_new <= t_lim), unsigned compare.
  - Display: "COLd" if t_act_new > t_lim; else "drOP" if drop_en; else "----" (segment g only).
  - done=1 for that cycle; busy=0.
- Latency: done is high exactly LAT = SUM_W + (SENSOR_W+2*FRAC_BITS)/2 + 1 cycles after the accept edge. Defaults: 10+12+1 = 23.
- Back-to-back: start asserted during the done cycle is accepted on the next edge. State is IDLE by then.
- Outputs hold their values between done pulses. The inputs may change freely while busy.

Optional Feature:
BAGGAGE_DROP_ROUND_EN
- Defined: the mean is rounded half-up, h = floor((2S + C) / (2C)). The divider runs SUM_W+1 cycles, so LAT grows by 1.
- Undefined: truncating divide and latency as above.
- Only the DIV stage differs.

Decomposition:
- Package baggage_drop_pkg holds:
  - state enum;
  - 7-segment glyph constants for C, O, L, d, r, P, '-' and blank;
  - a function computing SUM_W.
- One sub-module is natural: bd_isqrt, an iterative square root with start/done and parameter IN_W. The divider stays inline.

Test Plan:
- Sensors {64,64,64,64}, t_lim=1024, drop_en=1 -> after 23 cycles t_act=1024, drop_activated=1, display "drOP", one-cycle done.
- Sensors {100,0,100,0}, t_lim=1279, drop_en=1 -> t_act=1280, drop_activated=0, "COLd". Repeat with t_lim=1280 -> drop_activated=1.
- Sensors all 0, drop_en=0, t_lim=5 -> t_act=0, drop_activated=0, "----". Latency is still 23.
- Sensors {1,2,0,0} (S=3, C=2):
  - h=1 -> t_act=128 without the macro.
  - h=2 -> t_act=181 with BAGGAGE_DROP_ROUND_EN (floor(sqrt(2*65536))=362, halved), latency 24.
- Start pulsed again at cycle 5 of a run -> ignored, single done. Start held high through done -> second run accepted on the next edge.
- Assert rst asynchronously mid-SQRT -> busy, done, t_act, drop_activated and segments go to reset values immediately, with no done pulse. The next start runs normally.

Source files
------------

// File: rtl/baggage_drop_pkg.sv
// Shared types and constants for the sequential baggage-drop datapath.
// Optional feature macro: BAGGAGE_DROP_ROUND_EN (round-half-up mean).
package baggage_drop_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIV    = 2'd1,
        ST_SQRT   = 2'd2,
        ST_DECIDE = 2'd3
    } state_t;

    // Seven-segment glyphs, bit order gfedcba, active-high.
    localparam logic [6:0] SEG_C     = 7'b0111001;
    localparam logic [6:0] SEG_O     = 7'b0111111;
    localparam logic [6:0] SEG_L     = 7'b0111000;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_R     = 7'b1010000;
    localparam logic [6:0] SEG_P     = 7'b1110011;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic int sum_w(input int sensor_w, input int num_sensors);
        return sensor_w + ((num_sensors > 1) ? $clog2(num_sensors) : 1);
    endfunction

endpackage

// File: rtl/baggage_drop_seq_if.sv
// Request/result bundle between the sensor front-end and the baggage-drop sequencer.
interface baggage_drop_seq_if #(
    parameter int NUM_SENSORS = 4,
    parameter int SENSOR_W    = 8,
    parameter int T_W         = 16
);
    logic                            start;
    logic [NUM_SENSORS*SENSOR_W-1:0] sensors;
    logic [T_W-1:0]                  t_lim;
    logic                            drop_en;
    logic                            busy;
    logic                            done;
    logic [T_W-1:0]                  t_act;
    logic                            drop_activated;
    logic [6:0]                      seven_seg1;
    logic [6:0]                      seven_seg2;
    logic [6:0]                      seven_seg3;
    logic [6:0]                      seven_seg4;

    modport slave (
        input  start, sensors, t_lim, drop_en,
        output busy, done, t_act, drop_activated,
        output seven_seg1, seven_seg2, seven_seg3, seven_seg4
    );

    modport master (
        output start, sensors, t_lim, drop_en,
        input  busy, done, t_act, drop_activated,
        input  seven_seg1, seven_seg2, seven_seg3, seven_seg4
    );
endinterface

// File: rtl/bd_isqrt.sv
// Iterative digit-by-digit integer square root: start loads the radicand, then
// IN_W/2 edges each resolve one root bit; done is high in the cycle of the last one.
module bd_isqrt #(
    parameter int IN_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IN_W-1:0]   radicand,
    output logic              done,
    output logic [IN_W/2-1:0] root
);
    localparam int RW    = IN_W / 2;
    localparam int CNT_W = $clog2(RW + 1);

    logic [IN_W-1:0]  rad_q, rad_d;
    logic [RW+3:0]    rem_q, rem_d;
    logic [RW-1:0]    root_q, root_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RW+3:0]    rem_shift;
    logic [RW+3:0]    trial;

    always_comb begin
        rem_shift = (rem_q << 2) | (RW+4)'(rad_q[IN_W-1 -: 2]);
        trial     = (RW+4)'({root_q, 2'b01});
        rad_d     = rad_q;
        rem_d     = rem_q;
        root_d    = root_q;
        cnt_d     = cnt_q;
        if (start) begin
            rad_d  = radicand;
            rem_d  = '0;
            root_d = '0;
            cnt_d  = CNT_W'(RW);
        end else if (cnt_q != '0) begin
            rad_d = rad_q << 2;
            cnt_d = cnt_q - CNT_W'(1);
            if (rem_shift >= trial) begin
                rem_d  = rem_shift - trial;
                root_d = (root_q << 1) | RW'(1);
            end else begin
                rem_d  = rem_shift;
                root_d = root_q << 1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
        end else begin
            rad_q  <= rad_d;
            rem_q  <= rem_d;
            root_q <= root_d;
            cnt_q  <= cnt_d;
        end
    end

    assign done = (cnt_q == CNT_W'(1));
    assign root = root_q;

endmodule

// File: rtl/baggage_drop_seq.sv
// Sequential baggage-drop controller: mean height -> sqrt fall time -> drop decision + display.
// Optional feature macro: BAGGAGE_DROP_ROUND_EN (round-half-up mean, one extra divide cycle).
module baggage_drop_seq
    import baggage_drop_pkg::*;
#(
    parameter int NUM_SENSORS = 4,
    parameter int SENSOR_W    = 8,
    parameter int FRAC_BITS   = 8,
    parameter int T_W         = 16
) (
    input logic               clk,
    input logic               rst,
    baggage_drop_seq_if.slave bus
);
    localparam int SUM_W = sum_w(SENSOR_W, NUM_SENSORS);
    localparam int CNT_W = $clog2(NUM_SENSORS + 1);
`ifdef BAGGAGE_DROP_ROUND_EN
    localparam int DIV_W = SUM_W + 1;
`else
    localparam int DIV_W = SUM_W;
`endif
    localparam int DCNT_W  = $clog2(DIV_W + 1);
    localparam int SQ_IN_W = SENSOR_W + 2 * FRAC_BITS;
    localparam int RT_W    = SQ_IN_W / 2;

    if (T_W < RT_W) begin : g_tw_check
        $error("baggage_drop_seq: T_W must be at least SENSOR_W/2+FRAC_BITS");
    end
    if ((SENSOR_W % 2) != 0 || NUM_SENSORS < 1) begin : g_param_check
        $error("baggage_drop_seq: SENSOR_W must be even and NUM_SENSORS >= 1");
    end

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [T_W-1:0]     t_act_q, t_act_d;
    logic               drop_q, drop_d;
    logic [6:0]         seg1_q, seg1_d, seg2_q, seg2_d, seg3_q, seg3_d, seg4_q, seg4_d;
    logic [DCNT_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]   quo_q, quo_d;
    logic [DIV_W-1:0]   den_q, den_d;
    logic [DIV_W:0]     rem_q, rem_d;
    logic [T_W-1:0]     t_lim_q, t_lim_d;
    logic               drop_en_q, drop_en_d;

    logic [SUM_W-1:0]   sum;
    logic [CNT_W-1:0]   nz_cnt;
    logic [DIV_W:0]     rem_shift, step_rem;
    logic [DIV_W-1:0]   step_quo;
    logic [SENSOR_W-1:0] h;
    logic               sqrt_start, sqrt_done;
    logic [RT_W-1:0]    sq_root;
    logic [T_W-1:0]     t_new;
    logic               too_slow;

    // Zero readings are treated as absent sensors and excluded from the mean.
    always_comb begin
        sum    = '0;
        nz_cnt = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (bus.sensors[i*SENSOR_W +: SENSOR_W] != '0) begin
                sum    = sum + SUM_W'(bus.sensors[i*SENSOR_W +: SENSOR_W]);
                nz_cnt = nz_cnt + CNT_W'(1);
            end
        end
    end

    // One restoring-divide step; the final step feeds the square root directly.
    always_comb begin
        rem_shift = (rem_q << 1) | (DIV_W+1)'(quo_q[DIV_W-1]);
        if (rem_shift >= {1'b0, den_q}) begin
            step_rem = rem_shift - {1'b0, den_q};
            step_quo = (quo_q << 1) | DIV_W'(1);
        end else begin
            step_rem = rem_shift;
            step_quo = quo_q << 1;
        end
        if (den_q == '0) begin
            h = '0;
        end else if (|(step_quo >> SENSOR_W)) begin
            h = '1;
        end else begin
            h = step_quo[SENSOR_W-1:0];
        end
    end

    assign sqrt_start = (state_q == ST_DIV) && (cnt_q == DCNT_W'(1));

    bd_isqrt #(.IN_W(SQ_IN_W)) u_isqrt (
        .clk      (clk),
        .rst      (rst),
        .start    (sqrt_start),
        .radicand (SQ_IN_W'(h) << (2 * FRAC_BITS)),
        .done     (sqrt_done),
        .root     (sq_root)
    );

    assign t_new    = T_W'(sq_root >> 1);
    assign too_slow = (t_new > t_lim_q);

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        t_act_d   = t_act_q;
        drop_d    = drop_q;
        seg1_d    = seg1_q;
        seg2_d    = seg2_q;
        seg3_d    = seg3_q;
        seg4_d    = seg4_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        den_d     = den_q;
        rem_d     = rem_q;
        t_lim_d   = t_lim_q;
        drop_en_d = drop_en_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    t_lim_d   = bus.t_lim;
                    drop_en_d = bus.drop_en;
                    cnt_d     = DCNT_W'(DIV_W);
                    rem_d     = '0;
`ifdef BAGGAGE_DROP_ROUND_EN
                    quo_d     = DIV_W'({sum, 1'b0}) + DIV_W'(nz_cnt);
                    den_d     = DIV_W'({nz_cnt, 1'b0});
`else
                    quo_d     = sum;
                    den_d     = DIV_W'(nz_cnt);
`endif
                    busy_d    = 1'b1;
                    state_d   = ST_DIV;
                end
            end
            ST_DIV: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - DCNT_W'(1);
                if (cnt_q == DCNT_W'(1)) begin
                    state_d = ST_SQRT;
                end
            end
            ST_SQRT: begin
                if (sqrt_done) begin
                    state_d = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                t_act_d = t_new;
                drop_d  = drop_en_q && !too_slow;
                if (too_slow) begin
                    {seg1_d, seg2_d, seg3_d, seg4_d} = {SEG_C, SEG_O, SEG_L, SEG_D};
                end else if (drop_en_q) begin
                    {seg1_d, seg2_d, seg3_d, seg4_d} = {SEG_D, SEG_R, SEG_O, SEG_P};
                end else begin
                    {seg1_d, seg2_d, seg3_d, seg4_d} = {4{SEG_DASH}};
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            t_act_q   <= '0;
            drop_q    <= 1'b0;
            seg1_q    <= SEG_BLANK;
            seg2_q    <= SEG_BLANK;
            seg3_q    <= SEG_BLANK;
            seg4_q    <= SEG_BLANK;
            cnt_q     <= '0;
            quo_q     <= '0;
            den_q     <= '0;
            rem_q     <= '0;
            t_lim_q   <= '0;
            drop_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            t_act_q   <= t_act_d;
            drop_q    <= drop_d;
            seg1_q    <= seg1_d;
            seg2_q    <= seg2_d;
            seg3_q    <= seg3_d;
            seg4_q    <= seg4_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            den_q     <= den_d;
            rem_q     <= rem_d;
            t_lim_q   <= t_lim_d;
            drop_en_q <= drop_en_d;
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.t_act          = t_act_q;
    assign bus.drop_activated = drop_q;
    assign bus.seven_seg1     = seg1_q;
    assign bus.seven_seg2     = seg2_q;
    assign bus.seven_seg3     = seg3_q;
    assign bus.seven_seg4     = seg4_q;

endmodule

// File: tb/tb_baggage_drop_seq.sv
// Bench for baggage_drop_seq: directed plus random runs against an arithmetic reference model.
// Honours BAGGAGE_DROP_ROUND_EN when the design is built with it.
module tb_baggage_drop_seq;
    localparam int NS    = 4;
    localparam int SW    = 8;
    localparam int FB    = 8;
    localparam int TW    = 16;
    localparam int SUM_W = SW + $clog2(NS);
`ifdef BAGGAGE_DROP_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif
    localparam int LAT = SUM_W + RND + (SW + 2 * FB) / 2 + 1;

    localparam logic [6:0] G_C    = 7'h39;
    localparam logic [6:0] G_O    = 7'h3F;
    localparam logic [6:0] G_L    = 7'h38;
    localparam logic [6:0] G_D    = 7'h5E;
    localparam logic [6:0] G_R    = 7'h50;
    localparam logic [6:0] G_P    = 7'h73;
    localparam logic [6:0] G_DASH = 7'h40;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    baggage_drop_seq_if #(.NUM_SENSORS(NS), .SENSOR_W(SW), .T_W(TW)) bus ();

    baggage_drop_seq #(
        .NUM_SENSORS (NS),
        .SENSOR_W    (SW),
        .FRAC_BITS   (FB),
        .T_W         (TW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Mean of nonzero readings, floor(sqrt(h * 2^(2*FB))) found by search, halved.
    function automatic void model(input logic [31:0] sens, input logic [15:0] tlim, input logic den,
                                  output logic [15:0] t_exp, output logic drop_exp,
                                  output logic [27:0] seg_exp);
        longint s, c, h, r, t, v;
        s = 0;
        c = 0;
        for (int i = 0; i < NS; i++) begin
            v = longint'(sens[i*SW +: SW]);
            if (v != 0) begin
                s = s + v;
                c = c + 1;
            end
        end
        if (c == 0)        h = 0;
        else if (RND != 0) h = (2 * s + c) / (2 * c);
        else               h = s / c;
        if (h > 255) h = 255;
        r = h << (2 * FB);
        t = longint'($sqrt(real'(r)));
        while (t * t > r) t = t - 1;
        while ((t + 1) * (t + 1) <= r) t = t + 1;
        t_exp = 16'(t / 2);
        if (t_exp > tlim) begin
            drop_exp = 1'b0;
            seg_exp  = {G_C, G_O, G_L, G_D};
        end else if (den) begin
            drop_exp = 1'b1;
            seg_exp  = {G_D, G_R, G_O, G_P};
        end else begin
            drop_exp = 1'b0;
            seg_exp  = {4{G_DASH}};
        end
    endfunction

    // One full request; hold keeps start high so the next call is accepted back-to-back.
    task automatic applyStimulus(input logic [31:0] sens, input logic [15:0] tlim, input logic den,
                                 input bit hold, input int pulse_at, input int exp_t);
        logic [15:0] e_t;
        logic        e_drop;
        logic [27:0] e_seg;
        int          lat;
        int          extra;
        model(sens, tlim, den, e_t, e_drop, e_seg);
        bus.sensors = sens;
        bus.t_lim   = tlim;
        bus.drop_en = den;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("busy_at_accept", 32'(bus.busy), 32'd1);
        checkOutput("done_at_accept", 32'(bus.done), 32'd0);
        lat = -1;
        for (int i = 1; i <= LAT + 20; i++) begin
            bus.start   = hold || (i == pulse_at);
            bus.sensors = $urandom;
            bus.t_lim   = 16'($urandom);
            bus.drop_en = 1'($urandom);
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
        checkOutput("latency", 32'(lat), 32'(LAT));
        checkOutput("t_act", 32'(bus.t_act), 32'(e_t));
        if (exp_t >= 0) checkOutput("t_act_literal", 32'(bus.t_act), 32'(exp_t));
        checkOutput("drop_activated", 32'(bus.drop_activated), 32'(e_drop));
        checkOutput("segments", 32'({bus.seven_seg1, bus.seven_seg2, bus.seven_seg3, bus.seven_seg4}),
                    32'(e_seg));
        checkOutput("busy_at_done", 32'(bus.busy), 32'd0);
        if (!hold) begin
            bus.start = 1'b0;
            extra = (pulse_at > 0) ? LAT + 2 : 2;
            for (int k = 0; k < extra; k++) begin
                @(posedge clk);
                #1;
                checkOutput("done_single_pulse", 32'(bus.done), 32'd0);
                checkOutput("t_act_hold", 32'(bus.t_act), 32'(e_t));
            end
        end
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          dones;
        logic [31:0] rs;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.sensors = '0;
        bus.t_lim   = '0;
        bus.drop_en = 1'b0;
        #12;
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_t_act", 32'(bus.t_act), 32'd0);
        checkOutput("reset_drop", 32'(bus.drop_activated), 32'd0);
        checkOutput("reset_segments", 32'({bus.seven_seg1, bus.seven_seg2, bus.seven_seg3, bus.seven_seg4}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed runs");
        applyStimulus({8'd64, 8'd64, 8'd64, 8'd64}, 16'd1024, 1'b1, 1'b0, 0, 1024);
        applyStimulus({8'd0, 8'd100, 8'd0, 8'd100}, 16'd1279, 1'b1, 1'b0, 0, 1280);
        applyStimulus({8'd0, 8'd100, 8'd0, 8'd100}, 16'd1280, 1'b1, 1'b0, 0, 1280);
        applyStimulus(32'd0, 16'd5, 1'b0, 1'b0, 0, 0);
        applyStimulus({8'd0, 8'd0, 8'd2, 8'd1}, 16'hFFFF, 1'b1, 1'b0, 0, (RND != 0) ? 181 : 128);

        $display("[TB] start pulse while busy, then start held through done");
        applyStimulus({8'd64, 8'd64, 8'd64, 8'd64}, 16'd1024, 1'b1, 1'b0, 5, 1024);
        applyStimulus({8'd0, 8'd100, 8'd0, 8'd100}, 16'd1279, 1'b1, 1'b1, 0, 1280);
        applyStimulus({8'd80, 8'd70, 8'd60, 8'd50}, 16'hFFFF, 1'b1, 1'b0, 0, -1);

        $display("[TB] asynchronous reset during square root");
        bus.sensors = {8'd64, 8'd64, 8'd64, 8'd64};
        bus.t_lim   = 16'd2000;
        bus.drop_en = 1'b1;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (SUM_W + RND + 4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("midrun_reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("midrun_reset_done", 32'(bus.done), 32'd0);
        checkOutput("midrun_reset_t_act", 32'(bus.t_act), 32'd0);
        checkOutput("midrun_reset_drop", 32'(bus.drop_activated), 32'd0);
        checkOutput("midrun_reset_segments",
                    32'({bus.seven_seg1, bus.seven_seg2, bus.seven_seg3, bus.seven_seg4}), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (int k = 0; k < LAT + 5; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dones++;
        end
        checkOutput("no_done_after_abort", 32'(dones), 32'd0);
        applyStimulus({8'd25, 8'd36, 8'd49, 8'd0}, 16'd900, 1'b1, 1'b0, 0, -1);

        $display("[TB] randomized runs");
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < NS; i++) begin
                rs[i*SW +: SW] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            end
            applyStimulus(rs, 16'($urandom_range(0, 2047)), 1'($urandom_range(0, 1)), 1'b0, 0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
